// File: rtl/dvb_s2_pkg.sv
// Shared constants for the DVB-S2 modulator head: the fs_en generator FSM
// encoding, the default phase-accumulator width, and ready-made phase steps
// for the common symbol-rate ratios.
package dvb_s2_pkg;

  // Default width of the phase accumulator and of the phase step.
  localparam int unsigned FSG_ACC_WIDTH = 32;

  // fs_en generator FSM encoding; kept as plain constants so the encoding
  // is fixed and visible in waveforms and netlists.
  localparam logic [1:0] FSG_IDLE  = 2'd0;
  localparam logic [1:0] FSG_RUN   = 2'd1;
  localparam logic [1:0] FSG_DRAIN = 2'd2;

  // Phase steps giving one accumulator wrap every 4 and every 8 cycles.
  localparam logic [FSG_ACC_WIDTH-1:0] FSG_STEP_DIV4 = 32'h4000_0000;
  localparam logic [FSG_ACC_WIDTH-1:0] FSG_STEP_DIV8 = 32'h2000_0000;

  // Phase step for one wrap every 2^shift cycles (shift < FSG_ACC_WIDTH).
  function automatic logic [FSG_ACC_WIDTH-1:0] fsg_step_pow2(input int unsigned shift);
    logic [FSG_ACC_WIDTH-1:0] one;
    one = 1;
    return one << (FSG_ACC_WIDTH - shift);
  endfunction

endpackage

// File: rtl/fs_nco_acc.sv
// Phase accumulator (NCO) for the fs_en generator. Holds a shadow step
// register that is copied into the active step only when the accumulator
// wraps, or straight away while the generator is idle, so a rate change
// never produces a truncated period. tick_o is the accumulator carry.
module fs_nco_acc
  import dvb_s2_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = FSG_ACC_WIDTH
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 run_i,        // advance the accumulator
  input  logic                 idle_i,       // generator idle: load step now
  input  logic                 step_valid_i,
  input  logic [ACC_WIDTH-1:0] step_data_i,
  output logic                 tick_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] step_q, step_d;
  logic [ACC_WIDTH-1:0] shadow_q, shadow_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 wrap;

  // Next accumulator value, carry detection and step shadow/active update.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, step_q};
    wrap     = run_i & sum[ACC_WIDTH];
    shadow_d = step_valid_i ? step_data_i : shadow_q;
    step_d   = step_q;
    // A load arriving with the wrap bypasses the shadow, so the new step
    // is used from the very next cycle.
    if (idle_i || wrap) begin
      step_d = shadow_d;
    end
    // Outside RUN the accumulator sits at 0, so every restart begins a
    // full period.
    acc_d = run_i ? sum[ACC_WIDTH-1:0] : '0;
  end

  assign tick_o = wrap;

  // Accumulator, active step and shadow step registers.
  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      step_q   <= '0;
      shadow_q <= '0;
    end else begin
      acc_q    <= acc_d;
      step_q   <= step_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: rtl/fs_en_generator.sv
// Symbol-rate enable generator on sys_clk. An NCO produces overflow ticks
// at a programmable fractional rate; the ticks are decimated by DIV_RATIO,
// buffered in a pending-strobe counter and issued downstream as one-cycle
// fs_en pulses whenever fs_en_ready is high.
//
// Optional build macro FS_EN_STROBE_COUNT_EN adds the strobe_count
// (wrap-around count of issued pulses) and drop_count (saturating count of
// dropped ticks) outputs.
module fs_en_generator
  import dvb_s2_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = FSG_ACC_WIDTH,
  parameter int unsigned DIV_RATIO  = 2,
  parameter int unsigned PEND_DEPTH = 8
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          step_valid,
  input  logic [ACC_WIDTH-1:0]          step_data,
  output logic                          fs_en,
  input  logic                          fs_en_ready,
  output logic [$clog2(PEND_DEPTH):0]   pending,
  output logic                          overflow,
  output logic                          busy
`ifdef FS_EN_STROBE_COUNT_EN
  ,
  output logic [31:0]                   strobe_count,
  output logic [15:0]                   drop_count
`endif
);

  localparam int unsigned PEND_W = $clog2(PEND_DEPTH) + 1;
  localparam int unsigned DIV_W  = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;

  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_DEPTH);
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_RATIO - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              fs_en_q, fs_en_d;
  logic              ovf_q, ovf_d;

  logic in_run;
  logic in_idle;
  logic nco_tick;
  logic strobe_tick;
  logic issue;
  logic drop;
  logic accept;

  assign in_run  = (state_q == FSG_RUN);
  assign in_idle = (state_q == FSG_IDLE);

  fs_nco_acc #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_nco (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .run_i        (in_run),
    .idle_i       (in_idle),
    .step_valid_i (step_valid),
    .step_data_i  (step_data),
    .tick_o       (nco_tick)
  );

  // Decimate NCO ticks: every DIV_RATIO-th tick becomes a strobe tick.
  // Leaving RUN discards any partial decimation count.
  always_comb begin
    div_d       = div_q;
    strobe_tick = 1'b0;
    if (!in_run) begin
      div_d = '0;
    end else if (nco_tick) begin
      if (div_q == DIV_LAST) begin
        div_d       = '0;
        strobe_tick = 1'b1;
      end else begin
        div_d = div_q + DIV_ONE;
      end
    end
  end

  // Issue, drop and pending-count bookkeeping. A fresh strobe tick with
  // nothing buffered is issued in the same cycle, giving one cycle of
  // latency to fs_en.
  always_comb begin
    issue  = fs_en_ready & ((pend_q != '0) | strobe_tick);
    drop   = strobe_tick & (pend_q == PEND_FULL) & ~issue;
    accept = strobe_tick & ~drop;
    pend_d = pend_q;
    case ({accept, issue})
      2'b10:   pend_d = pend_q + PEND_ONE;
      2'b01:   pend_d = pend_q - PEND_ONE;
      default: pend_d = pend_q;
    endcase
    fs_en_d = issue;
    ovf_d   = ovf_q | drop;
  end

  // Run/drain control: DRAIN empties the pending buffer before IDLE, and a
  // renewed enable in DRAIN goes straight back to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FSG_IDLE: begin
        if (enable) state_d = FSG_RUN;
      end
      FSG_RUN: begin
        if (!enable) state_d = FSG_DRAIN;
      end
      FSG_DRAIN: begin
        if (enable)              state_d = FSG_RUN;
        else if (pend_q == '0)   state_d = FSG_IDLE;
      end
      default: state_d = FSG_IDLE;
    endcase
  end

  // FSM, decimation counter, pending counter, strobe and sticky overflow.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FSG_IDLE;
      div_q   <= '0;
      pend_q  <= '0;
      fs_en_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      fs_en_q <= fs_en_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fs_en    = fs_en_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == FSG_RUN) || (state_q == FSG_DRAIN);

`ifdef FS_EN_STROBE_COUNT_EN
  logic [31:0] strobe_cnt_q;
  logic [15:0] drop_cnt_q;

  // Issued-pulse counter (wraps) and dropped-tick counter (saturates).
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      if (issue) begin
        strobe_cnt_q <= strobe_cnt_q + 32'd1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign strobe_count = strobe_cnt_q;
  assign drop_count   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fs_en_generator.sv
// Scoreboard bench for fs_en_generator: directed sequences push the
// hand-computed cycle numbers of expected fs_en pulses into a queue, and an
// independent monitor pops and compares each pulse the DUT produces.
module tb_fs_en_generator;

  logic        sys_clk;
  logic        rst_n;
  logic        enable;
  logic        step_valid;
  logic [31:0] step_data;
  logic        fs_en;
  logic        fs_en_ready;
  logic [3:0]  pending;
  logic        overflow;
  logic        busy;
`ifdef FS_EN_STROBE_COUNT_EN
  logic [31:0] strobe_count;
  logic [15:0] drop_count;
`endif

  fs_en_generator #(
    .ACC_WIDTH  (32),
    .DIV_RATIO  (2),
    .PEND_DEPTH (8)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .step_valid  (step_valid),
    .step_data   (step_data),
    .fs_en       (fs_en),
    .fs_en_ready (fs_en_ready),
    .pending     (pending),
    .overflow    (overflow),
    .busy        (busy)
`ifdef FS_EN_STROBE_COUNT_EN
    ,
    .strobe_count (strobe_count),
    .drop_count   (drop_count)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Clock period index: value k holds between posedge k and posedge k+1.
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Advance to period `target`, 1 time unit after its rising edge.
  task automatic goto_cycle(input int target);
    while (cyc < target) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Monitor: every fs_en pulse must match the next expected cycle.
  always @(negedge sys_clk) begin
    if (fs_en === 1'b1) begin
      check("fs_en_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("fs_en_cycle", 64'(cyc), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int n;
    int p;
    int r;
    int q;
    int max_pend;

    rst_n       = 1'b0;
    enable      = 1'b0;
    step_valid  = 1'b0;
    step_data   = '0;
    fs_en_ready = 1'b1;

    // Reset state.
    #12;
    check("rst_fs_en", 64'(fs_en), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    goto_cycle(3);
    rst_n = 1'b1;

    // step=0 in RUN: no ticks at all.
    enable = 1'b1;
    goto_cycle(cyc + 40);
    check("step0_pending", 64'(pending), 64'd0);
    check("step0_busy", 64'(busy), 64'd1);
    enable = 1'b0;
    goto_cycle(cyc + 3);
    check("step0_idle", 64'(busy), 64'd0);

    // Basic rate: step 1/4, DIV_RATIO 2 -> pulse every 8 cycles,
    // first one 8 cycles after RUN entry.
    n = cyc;
    step_valid = 1'b1;
    step_data  = 32'h4000_0000;
    enable     = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back(n + 9 + 8 * k);
    goto_cycle(n + 1);
    step_valid = 1'b0;
    max_pend = 0;
    while (cyc < n + 41) begin
      if (int'(pending) > max_pend) max_pend = int'(pending);
      goto_cycle(cyc + 1);
    end
    check("basic_pending_le1", 64'(max_pend <= 1), 64'd1);
    check("basic_overflow", 64'(overflow), 64'd0);

    // Backpressure: 100 cycles without ready -> 12 strobe ticks, 8 kept,
    // 4 dropped. Then drain: 8 back-to-back pulses.
    goto_cycle(n + 42);
    fs_en_ready = 1'b0;
    goto_cycle(n + 142);
    check("bp_pending_full", 64'(pending), 64'd8);
    check("bp_overflow", 64'(overflow), 64'd1);
    enable = 1'b0;
    goto_cycle(n + 143);
    fs_en_ready = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(n + 144 + k);
    goto_cycle(n + 153);
    check("bp_drained_busy", 64'(busy), 64'd0);
    check("bp_drained_pending", 64'(pending), 64'd0);
    check("bp_overflow_sticky", 64'(overflow), 64'd1);

    // Step change mid-period: 1/4 -> 1/8 applied at the next wrap.
    // Pulse gaps: 12 cycles once, then 16.
    p = cyc;
    enable = 1'b1;
    exp_q.push_back(p + 9);
    exp_q.push_back(p + 21);
    exp_q.push_back(p + 37);
    exp_q.push_back(p + 53);
    goto_cycle(p + 10);
    step_valid = 1'b1;
    step_data  = 32'h2000_0000;
    goto_cycle(p + 11);
    step_valid = 1'b0;

    // Drain: build pending=3, then drop enable with ready high.
    goto_cycle(p + 54);
    fs_en_ready = 1'b0;
    goto_cycle(p + 102);
    check("drain_pending3", 64'(pending), 64'd3);
    enable      = 1'b0;
    fs_en_ready = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(p + 103 + k);
    goto_cycle(p + 106);
    check("drain_busy", 64'(busy), 64'd0);
    check("drain_pending0", 64'(pending), 64'd0);
    goto_cycle(cyc + 30);

    // Asynchronous reset with pending=5.
    r = cyc;
    step_valid  = 1'b1;
    step_data   = 32'h4000_0000;
    enable      = 1'b1;
    fs_en_ready = 1'b0;
    goto_cycle(r + 1);
    step_valid = 1'b0;
    goto_cycle(r + 42);
    check("prerst_pending5", 64'(pending), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_fs_en", 64'(fs_en), 64'd0);
    check("arst_pending", 64'(pending), 64'd0);
    check("arst_overflow", 64'(overflow), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    goto_cycle(cyc + 2);
    q = cyc;
    rst_n       = 1'b1;
    step_valid  = 1'b1;
    step_data   = 32'h4000_0000;
    fs_en_ready = 1'b1;
    exp_q.push_back(q + 9);
    exp_q.push_back(q + 17);
    goto_cycle(q + 1);
    step_valid = 1'b0;
    goto_cycle(q + 18);
    enable = 1'b0;
    goto_cycle(cyc + 5);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_overflow", 64'(overflow), 64'd0);

`ifdef FS_EN_STROBE_COUNT_EN
    begin
      int s;
      int t;
      rst_n = 1'b0;
      goto_cycle(cyc + 1);
      rst_n = 1'b1;
      check("cnt_rst_strobe", 64'(strobe_count), 64'd0);
      check("cnt_rst_drop", 64'(drop_count), 64'd0);
      // 12 strobe ticks with ready low: 8 buffered, 4 dropped.
      s = cyc;
      step_valid  = 1'b1;
      step_data   = 32'h4000_0000;
      enable      = 1'b1;
      fs_en_ready = 1'b0;
      goto_cycle(s + 1);
      step_valid = 1'b0;
      goto_cycle(s + 97);
      enable = 1'b0;
      goto_cycle(s + 98);
      fs_en_ready = 1'b1;
      for (int k = 0; k < 8; k++) exp_q.push_back(s + 99 + k);
      goto_cycle(s + 110);
      check("cnt_mid_strobe", 64'(strobe_count), 64'd8);
      check("cnt_mid_drop", 64'(drop_count), 64'd4);
      // 992 more pulses at the basic rate.
      t = cyc;
      enable = 1'b1;
      for (int k = 0; k < 992; k++) exp_q.push_back(t + 9 + 8 * k);
      goto_cycle(t + 7938);
      enable = 1'b0;
      goto_cycle(cyc + 10);
      check("cnt_strobe_1000", 64'(strobe_count), 64'd1000);
      check("cnt_drop_4", 64'(drop_count), 64'd4);
      check("cnt_overflow", 64'(overflow), 64'd1);
    end
`endif

    goto_cycle(cyc + 5);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
